// File: rtl/aes_ctrl_pkg.sv
// Shared constants, state encoding and Rcon helper for the AES round sequencer.
// The ERR state exists only when AES_WATCHDOG_EN is defined.
package aes_ctrl_pkg;

    localparam int NUM_ROUNDS   = 10;
    localparam int ROUND_CYCLES = 21;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
`ifdef AES_WATCHDOG_EN
        ,
        ERR
`endif
    } state_t;

    // GF(2^8) doubling: Rcon(i+1) = xtime(Rcon(i))
    function automatic logic [7:0] xtime(input logic [7:0] ValxD);
        return {ValxD[6:0], 1'b0} ^ (ValxD[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: cleared by reset or ClearxSI, loaded with RCON_INIT,
// advanced by xtime once per completed round.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       ClkxCI,
    input  logic       RstxRI,
    input  logic       ClearxSI,
    input  logic       InitxSI,
    input  logic       AdvancexSI,
    output logic [7:0] RconxDO
);

    logic [7:0] RconxDP;

    // NOTE: flops use non-blocking <= so every register samples pre-edge values.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI || ClearxSI) begin
            RconxDP <= 8'h00;
        end else if (InitxSI) begin
            RconxDP <= RCON_INIT;
        end else if (AdvancexSI) begin
            RconxDP <= xtime(RconxDP);
        end
    end

    assign RconxDO = RconxDP;

endmodule

// File: rtl/aes_round_ctrl.sv
// Round-level sequencer for the serialized AES datapath.
// Optional watchdog and sticky error state enabled by defining AES_WATCHDOG_EN.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
(
    input  logic       ClkxCI,
    input  logic       RstxRI,
    input  logic       InValidxSI,
    output logic       InReadyxSO,
    output logic       LoadxSO,
    output logic       CoreStartxSO,
    input  logic       CoreRoundEndxSI,
    output logic       LastRoundxSO,
    output logic [3:0] RoundxDO,
    output logic [7:0] RconxDO,
    output logic       BusyxSO,
    output logic       OutValidxSO,
    input  logic       OutReadyxSI,
    output logic       ErrorxSO
);

    state_t     StatexDP, StatexDN;
    logic [3:0] RoundxDP, RoundxDN;
    logic       RconInitxS, RconAdvxS, RconClrxS;
    logic       LastxS;

`ifdef AES_WATCHDOG_EN
    logic [4:0] CntxDP, CntxDN;
    logic       ErrxDP;
    logic       WdFaultxS;
`endif

    assign LastxS = (RoundxDP == LAST_ROUND);

`ifdef AES_WATCHDOG_EN
    // A round must end exactly ROUND_CYCLES cycles after it started; any end pulse
    // outside RUN is also a protocol violation.
    always_comb begin
        WdFaultxS = 1'b0;
        if (StatexDP == RUN) begin
            if (CoreRoundEndxSI) begin
                WdFaultxS = (CntxDP != 5'(ROUND_CYCLES - 1));
            end else begin
                WdFaultxS = (CntxDP == 5'(ROUND_CYCLES - 1));
            end
        end else if (StatexDP != ERR) begin
            WdFaultxS = CoreRoundEndxSI;
        end
    end

    always_comb begin
        CntxDN = CntxDP;
        if (StatexDP == LOAD) begin
            CntxDN = '0;
        end else if (StatexDP == RUN) begin
            CntxDN = CoreRoundEndxSI ? 5'd0 : CntxDP + 5'd1;
        end
    end
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        StatexDN     = StatexDP;
        RoundxDN     = RoundxDP;
        RconInitxS   = 1'b0;
        RconAdvxS    = 1'b0;
        RconClrxS    = 1'b0;
        InReadyxSO   = 1'b0;
        LoadxSO      = 1'b0;
        CoreStartxSO = 1'b0;
        BusyxSO      = 1'b0;
        OutValidxSO  = 1'b0;

        case (StatexDP)
            IDLE: begin
                InReadyxSO = 1'b1;
                if (InValidxSI) StatexDN = LOAD;
            end
            LOAD: begin
                LoadxSO      = 1'b1;
                CoreStartxSO = 1'b1;
                BusyxSO      = 1'b1;
                RoundxDN     = 4'd1;
                RconInitxS   = 1'b1;
                StatexDN     = RUN;
            end
            RUN: begin
                BusyxSO = 1'b1;
                if (CoreRoundEndxSI) begin
                    if (LastxS) begin
                        StatexDN = DONE;
                    end else begin
                        RoundxDN  = RoundxDP + 4'd1;
                        RconAdvxS = 1'b1;
                    end
                end
            end
            DONE: begin
                OutValidxSO = 1'b1;
                if (OutReadyxSI) begin
                    InReadyxSO = 1'b1;
                    if (InValidxSI) begin
                        StatexDN = LOAD;
                    end else begin
                        StatexDN  = IDLE;
                        RoundxDN  = '0;
                        RconClrxS = 1'b1;
                    end
                end
            end
`ifdef AES_WATCHDOG_EN
            ERR: StatexDN = ERR;
`endif
            default: StatexDN = IDLE;
        endcase

`ifdef AES_WATCHDOG_EN
        // A fault freezes round bookkeeping; only reset leaves ERR.
        if (WdFaultxS) begin
            StatexDN   = ERR;
            RoundxDN   = RoundxDP;
            RconInitxS = 1'b0;
            RconAdvxS  = 1'b0;
            RconClrxS  = 1'b0;
        end
`endif
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            StatexDP <= IDLE;
            RoundxDP <= '0;
        end else begin
            StatexDP <= StatexDN;
            RoundxDP <= RoundxDN;
        end
    end

`ifdef AES_WATCHDOG_EN
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            CntxDP <= '0;
            ErrxDP <= 1'b0;
        end else begin
            CntxDP <= CntxDN;
            ErrxDP <= ErrxDP | WdFaultxS;
        end
    end

    assign ErrorxSO = ErrxDP;
`else
    assign ErrorxSO = 1'b0;
`endif

    aes_rcon_gen u_rcon_gen (
        .ClkxCI     (ClkxCI),
        .RstxRI     (RstxRI),
        .ClearxSI   (RconClrxS),
        .InitxSI    (RconInitxS),
        .AdvancexSI (RconAdvxS),
        .RconxDO    (RconxDO)
    );

    assign RoundxDO     = RoundxDP;
    assign LastRoundxSO = (StatexDP == RUN) && LastxS;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl (default build): reset/table vectors,
// directed multi-cycle sequences and randomized traffic against a timing model.
module tb_aes_round_ctrl;

    localparam int NR  = 10;
    localparam int RC  = 21;
    localparam int LAT = 2 + NR * RC;

    logic       ClkxCI = 1'b0;
    logic       RstxRI;
    logic       InValidxSI;
    logic       InReadyxSO;
    logic       LoadxSO;
    logic       CoreStartxSO;
    logic       CoreRoundEndxSI;
    logic       LastRoundxSO;
    logic [3:0] RoundxDO;
    logic [7:0] RconxDO;
    logic       BusyxSO;
    logic       OutValidxSO;
    logic       OutReadyxSI;
    logic       ErrorxSO;

    always #5 ClkxCI = ~ClkxCI;

    aes_round_ctrl dut (
        .ClkxCI          (ClkxCI),
        .RstxRI          (RstxRI),
        .InValidxSI      (InValidxSI),
        .InReadyxSO      (InReadyxSO),
        .LoadxSO         (LoadxSO),
        .CoreStartxSO    (CoreStartxSO),
        .CoreRoundEndxSI (CoreRoundEndxSI),
        .LastRoundxSO    (LastRoundxSO),
        .RoundxDO        (RoundxDO),
        .RconxDO         (RconxDO),
        .BusyxSO         (BusyxSO),
        .OutValidxSO     (OutValidxSO),
        .OutReadyxSI     (OutReadyxSI),
        .ErrorxSO        (ErrorxSO)
    );

    int nVec  = 0;
    int nFail = 0;
    int cyc   = 0;

    // Reference model: a block is described only by the cycle its request was accepted.
    bit   active  = 1'b0;
    bit   b2b     = 1'b0;
    int   tReq    = 0;
    int   cs      = -1;
    bit   ovPrev  = 1'b0;
    int   riseQ[$];
    logic [7:0] rconTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    typedef struct {
        bit         inV;
        bit         outR;
        bit         endP;
        bit         expReady;
        bit         expLoad;
        bit         expBusy;
        bit         expOv;
        logic [3:0] expRound;
        logic [7:0] expRcon;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // 0 idle, 1 load, 2 running, 3 result waiting
    function automatic int phase_of();
        int d;
        if (!active) return 0;
        d = cyc - tReq;
        if (d == 1) return 1;
        if (d < LAT) return 2;
        return 3;
    endfunction

    task automatic tick(input bit inV, input bit outR, input bit stray, input bit rst);
        int         ph;
        int         d;
        int         rnd;
        logic [7:0] rc;
        bit         sched;
        ph    = phase_of();
        d     = cyc - tReq;
        sched = (cs >= 0) && (cyc > cs) && ((cyc - cs) % RC == 0) && ((cyc - cs) / RC <= NR);
        InValidxSI      = inV;
        OutReadyxSI     = outR;
        RstxRI          = rst;
        CoreRoundEndxSI = sched | (stray && (ph == 0 || ph == 3));
        #2;
        case (ph)
            1:       begin rnd = b2b ? NR : 0;  rc = b2b ? 8'h36 : 8'h00; end
            2:       begin rnd = (d - 2) / RC + 1; rc = rconTab[rnd - 1]; end
            3:       begin rnd = NR; rc = 8'h36; end
            default: begin rnd = 0;  rc = 8'h00; end
        endcase
        check("in_ready",   InReadyxSO,   (ph == 0) || (ph == 3 && outR));
        check("load",       LoadxSO,      ph == 1);
        check("core_start", CoreStartxSO, ph == 1);
        check("busy",       BusyxSO,      ph == 1 || ph == 2);
        check("out_valid",  OutValidxSO,  ph == 3);
        check("last_round", LastRoundxSO, ph == 2 && rnd == NR);
        check("round",      RoundxDO,     rnd);
        check("rcon",       RconxDO,      rc);
        check("error",      ErrorxSO,     0);
        if (OutValidxSO === 1'b1 && !ovPrev) riseQ.push_back(cyc);
        ovPrev = (OutValidxSO === 1'b1);
        if (CoreStartxSO === 1'b1) cs = cyc;
        if (rst) begin
            active = 1'b0;
            cs     = -1;
        end else if ((ph == 0 || (ph == 3 && outR)) && inV) begin
            b2b    = (ph == 3);
            active = 1'b1;
            tReq   = cyc;
        end else if (ph == 3 && outR) begin
            active = 1'b0;
        end
        @(posedge ClkxCI);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RstxRI          = 1'b1;
        InValidxSI      = 1'b0;
        OutReadyxSI     = 1'b0;
        CoreRoundEndxSI = 1'b0;
        repeat (2) @(posedge ClkxCI);
        #1;
        RstxRI = 1'b0;
        active = 1'b0;
        cs     = -1;
        ovPrev = 1'b0;
        cyc   += 2;
    endtask

    initial begin
        int tA;
        tbl[0] = '{0, 0, 0, 1, 0, 0, 0, 4'd0, 8'h00};
        tbl[1] = '{0, 0, 1, 1, 0, 0, 0, 4'd0, 8'h00};
        tbl[2] = '{1, 0, 0, 1, 0, 0, 0, 4'd0, 8'h00};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 0, 4'd0, 8'h00};
        tbl[4] = '{0, 0, 0, 0, 0, 1, 0, 4'd1, 8'h01};
        tbl[5] = '{1, 1, 0, 0, 0, 1, 0, 4'd1, 8'h01};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            InValidxSI      = tbl[i].inV;
            OutReadyxSI     = tbl[i].outR;
            CoreRoundEndxSI = tbl[i].endP;
            #2;
            check("tbl_ready",  InReadyxSO,   tbl[i].expReady);
            check("tbl_load",   LoadxSO,      tbl[i].expLoad);
            check("tbl_start",  CoreStartxSO, tbl[i].expLoad);
            check("tbl_busy",   BusyxSO,      tbl[i].expBusy);
            check("tbl_ovalid", OutValidxSO,  tbl[i].expOv);
            check("tbl_last",   LastRoundxSO, 0);
            check("tbl_round",  RoundxDO,     tbl[i].expRound);
            check("tbl_rcon",   RconxDO,      tbl[i].expRcon);
            @(posedge ClkxCI);
            #1;
            cyc++;
        end

        // Single block, result taken as soon as it appears.
        do_reset();
        riseQ.delete();
        tA = cyc;
        tick(1, 0, 0, 0);
        for (int i = 0; i < LAT + 3; i++) tick(0, 1, 0, 0);
        check("latency_single", (riseQ.size() > 0) ? riseQ[0] - tA : -1, LAT);

        // Back-pressure for 50 cycles with stray end pulses in DONE, then release.
        tick(1, 0, 0, 0);
        for (int i = 0; i < LAT - 1; i++) tick(0, 0, 0, 0);
        for (int i = 0; i < 50; i++) tick(0, 0, (i % 7) == 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);

        // Back-to-back blocks with both handshakes held high.
        riseQ.delete();
        tA = cyc;
        for (int i = 0; i < 2 * LAT + 5; i++) tick(1, 1, 0, 0);
        check("latency_b2b_first", (riseQ.size() > 0) ? riseQ[0] - tA : -1, LAT);
        check("b2b_period", (riseQ.size() > 1) ? riseQ[1] - riseQ[0] : -1, LAT);
        for (int i = 0; i < LAT + 2; i++) tick(0, 1, 0, 0);

        // Reset in round 5, then a fresh block completes normally.
        tA = cyc;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 2 + 4 * RC + 4; i++) tick(0, 0, 0, 0);
        check("round_before_reset", RoundxDO, 5);
        tick(0, 0, 0, 1);
        riseQ.delete();
        tA = cyc;
        tick(1, 1, 0, 0);
        for (int i = 0; i < LAT + 2; i++) tick(0, 1, 0, 0);
        check("latency_after_reset", (riseQ.size() > 0) ? riseQ[0] - tA : -1, LAT);

        // Randomized traffic, back-pressure, stray pulses and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 999) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
